// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash reader.
package spi_flash_pkg;

  // Standard serial-flash READ opcode (no dummy cycles).
  localparam logic [7:0] READ_OP   = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: divides wb clock by 2*CLK_DIV, idles low (mode 0) and
// emits single-cycle strobes on the edge where SCK is about to rise/fall.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic stall_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  assign tick   = en_i && !stall_i && (cnt_q == TERM);
  assign rise_o = tick && !sck_q;
  assign fall_o = tick && sck_q;
  assign sck_o  = sck_q;

  // Next-state: count half-periods, toggle SCK at terminal count, freeze on stall.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (!stall_i) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Divider state; disabling the generator returns SCK low with a fresh count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash READ (0x03) master streaming a byte range onto a valid/ready
// byte interface with backpressure that freezes SCK at byte boundaries.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CSB_IDLE = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  data_o,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        spi_csb,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int            GW       = (CSB_IDLE > 1) ? $clog2(CSB_IDLE) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((CSB_IDLE > 1) ? CSB_IDLE - 1 : 0);

  state_e        state_q;
  logic [31:0]   out_q;
  logic [7:0]    shift_q;
  logic [4:0]    bit_q;
  logic [15:0]   bytes_q;
  logic [GW-1:0] gap_q;
  logic          byte_rdy_q;
  logic [7:0]    data_q;
  logic          dv_q;
  logic          busy_q;
  logic          done_q;
  logic          csb_q;
  logic          mosi_q;

  logic gen_en, stall, sck, rise, fall;

  assign gen_en = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  // Hold SCK low before the first edge of a new byte while the output register is still full.
  assign stall  = (state_q == ST_DATA) && (bit_q == 5'd0) && !sck && dv_q && !data_ready;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .en_i   (gen_en),
    .stall_i(stall),
    .sck_o  (sck),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_o     = data_q;
  assign data_valid = dv_q;
  assign spi_csb    = csb_q;
  assign spi_sck    = sck;
  assign spi_mosi   = mosi_q;

  // Transfer FSM with registered outputs, shift registers and output byte register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      bytes_q    <= '0;
      gap_q      <= '0;
      byte_rdy_q <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      csb_q      <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      byte_rdy_q <= 1'b0;

      // A freshly assembled byte takes priority over a same-cycle consume.
      if (byte_rdy_q) begin
        data_q <= shift_q;
        dv_q   <= 1'b1;
      end else if (dv_q && data_ready) begin
        dv_q <= 1'b0;
      end

      // MOSI only moves on falling edges; zeros shift in so DATA drives 0.
      if (fall) begin
        mosi_q <= out_q[31];
        out_q  <= {out_q[30:0], 1'b0};
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              csb_q   <= 1'b0;
              mosi_q  <= READ_OP[7];
              out_q   <= {READ_OP[6:0], addr, 1'b0};
              bit_q   <= '0;
              bytes_q <= len;
              state_q <= ST_CMD;
            end
          end
        end

        ST_CMD: begin
          if (rise) begin
            if (bit_q == 5'(CMD_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= ST_ADDR;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end

        ST_ADDR: begin
          if (rise) begin
            if (bit_q == 5'(ADDR_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= ST_DATA;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end

        ST_DATA: begin
          if (rise) begin
            shift_q <= {shift_q[6:0], spi_miso};
            if (bit_q == 5'd7) begin
              bit_q      <= '0;
              byte_rdy_q <= 1'b1;
              bytes_q    <= bytes_q - 16'd1;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
          // CSB rises on the would-be falling edge after the final byte.
          if (fall && (bytes_q == 16'd0)) begin
            csb_q   <= 1'b1;
            gap_q   <= '0;
            state_q <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (!dv_q && !byte_rdy_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader: three instances (CLK_DIV 2, 1, 5),
// each with a behavioural SPI flash whose byte at address a is (a-16)*17.
module tb_spi_flash_reader;

  localparam int CSB_IDLE = 2;

  typedef struct packed {
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] addr;
  logic [15:0] len;
  logic [2:0]  start;
  logic [2:0]  rdy;
  wire  [2:0]  busy, done, dv, csb, sck, mosi, miso;
  wire  [7:0]  dout [0:2];

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] exp_q [$];
  chk_t       chk_q [$];
  string      nm_q  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [23:0] t;
    logic [7:0]  b;
    t = a - 24'd16;
    b = t[7:0];
    return b * 8'd17;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : fl
    localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic        miso_r = 1'b0;
    logic        sck_p = 1'b0, csb_p = 1'b1, mosi_p = 1'b0;
    logic [31:0] ca = '0;
    logic [7:0]  b;
    int bitn = 0, k = 0, rises = 0, falls_csb = 0, dones = 0, mosi_bad = 0;
    int t_csbf = 0, t_r1 = 0, t_r2 = 0, t_rlast = 0, t_csbr = 0, t_done = 0;

    assign miso[g] = miso_r;

    spi_flash_reader #(.CLK_DIV(D), .CSB_IDLE(CSB_IDLE)) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .start     (start[g]),
      .addr      (addr),
      .len       (len),
      .busy      (busy[g]),
      .done      (done[g]),
      .data_o    (dout[g]),
      .data_valid(dv[g]),
      .data_ready(rdy[g]),
      .spi_csb   (csb[g]),
      .spi_sck   (sck[g]),
      .spi_mosi  (mosi[g]),
      .spi_miso  (miso[g])
    );

    // Flash model: captures command/address on rises, drives data on falls.
    always @(negedge clk) begin
      if (csb_p && !csb[g]) begin
        falls_csb++;
        t_csbf = cyc;
        bitn   = 0;
      end
      if (!csb_p && csb[g]) t_csbr = cyc;
      if (done[g]) begin
        dones++;
        t_done = cyc;
      end
      if (!csb[g] && !sck_p && sck[g]) begin
        rises++;
        if (bitn < 32) ca = {ca[30:0], mosi[g]};
        if (bitn == 0) t_r1 = cyc;
        if (bitn == 1) t_r2 = cyc;
        t_rlast = cyc;
        bitn++;
      end
      if (!csb[g] && sck_p && !sck[g] && bitn >= 32) begin
        k      = bitn - 32;
        b      = fbyte(ca[23:0] + 24'(k / 8));
        miso_r = b[7 - (k % 8)];
      end
      if (sck_p && sck[g] && (mosi[g] != mosi_p)) mosi_bad++;
      sck_p  = sck[g];
      csb_p  = csb[g];
      mosi_p = mosi[g];
    end
  end

  // Monitor: compares every accepted byte against the expected queue and
  // drains the queue of directed checks issued by the stimulus process.
  always @(negedge clk) begin
    chk_t  c;
    string nm;
    logic [7:0] e;
    for (int g = 0; g < 3; g++) begin
      if (dv[g] && rdy[g]) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL byte_inst%0d: got %02h, expected no byte", g, dout[g]);
        end else begin
          e = exp_q.pop_front();
          if (dout[g] !== e) begin
            fails++;
            $display("FAIL byte_inst%0d: got %02h expected %02h", g, dout[g], e);
          end
        end
      end
    end
    while (chk_q.size() > 0) begin
      c  = chk_q.pop_front();
      nm = nm_q.pop_front();
      tests++;
      if (c.act !== c.exp) begin
        fails++;
        $display("FAIL %s: got %0h expected %0h", nm, c.act, c.exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nm_q.push_back(nm);
    chk_q.push_back('{act: act, exp: exp});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int g, input logic [23:0] a, input logic [15:0] l);
    @(posedge clk);
    #1;
    addr     = a;
    len      = l;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string nm);
    int n = 0;
    while (!done[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(done[g]), 32'd1);
  endtask

  task automatic push_hex(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  initial begin
    int r0, d0, f0, ra, n;
    rst   = 1'b1;
    start = '0;
    rdy   = 3'b111;
    addr  = '0;
    len   = '0;

    // Reset values
    tick(3);
    @(negedge clk);
    chk("rst_csb",  32'(csb),     32'h7);
    chk("rst_sck",  32'(sck),     32'h0);
    chk("rst_mosi", 32'(mosi),    32'h0);
    chk("rst_busy", 32'(busy),    32'h0);
    chk("rst_done", 32'(done),    32'h0);
    chk("rst_dv",   32'(dv),      32'h0);
    chk("rst_dout", 32'(dout[0]), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Basic read of 00 11 22 33 at 0x000010
    r0 = fl[0].rises;
    d0 = fl[0].dones;
    push_hex(32'h00112233);
    pulse_start(0, 24'h000010, 16'd4);
    @(negedge clk);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    chk("t1_csb",  32'(csb[0]),  32'd0);
    chk("t1_mosi", 32'(mosi[0]), 32'd0);
    wait_done(0, 2000, "t1_done");
    chk("t1_busy_at_done", 32'(busy[0]), 32'd0);
    tick(4);
    chk("t1_cmdaddr", fl[0].ca,                      32'h03000010);
    chk("t1_rises",   32'(fl[0].rises - r0),         32'd64);
    chk("t1_dones",   32'(fl[0].dones - d0),         32'd1);
    chk("t1_first",   32'(fl[0].t_r1 - fl[0].t_csbf), 32'd2);
    chk("t1_period",  32'(fl[0].t_r2 - fl[0].t_r1),   32'd4);
    chk("t1_csbrise", 32'(fl[0].t_csbr - fl[0].t_rlast), 32'd2);
    chk("t1_gap",     32'(fl[0].t_done - fl[0].t_csbr),  32'(CSB_IDLE));
    chk("t1_qempty",  32'(exp_q.size()),             32'd0);

    // Backpressure: ready low for 100 cycles after the first byte
    r0 = fl[0].rises;
    push_hex(32'h00112233);
    pulse_start(0, 24'h000010, 16'd4);
    n = 0;
    while (!dv[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first", 32'(dv[0]), 32'd1);
    @(posedge clk);
    #1;
    rdy[0] = 1'b0;
    tick(60);
    @(negedge clk);
    ra = fl[0].rises;
    tick(40);
    @(negedge clk);
    chk("bp_frozen", 32'(fl[0].rises), 32'(ra));
    chk("bp_csb",    32'(csb[0]), 32'd0);
    chk("bp_sck",    32'(sck[0]), 32'd0);
    chk("bp_dv",     32'(dv[0]),  32'd1);
    tick(1);
    rdy[0] = 1'b1;
    wait_done(0, 2000, "bp_done");
    tick(4);
    chk("bp_rises",  32'(fl[0].rises - r0), 32'd64);
    chk("bp_qempty", 32'(exp_q.size()), 32'd0);

    // len = 0: immediate done, no SPI activity
    f0 = fl[0].falls_csb;
    pulse_start(0, 24'h123456, 16'd0);
    @(negedge clk);
    chk("l0_done", 32'(done[0]), 32'd1);
    chk("l0_busy", 32'(busy[0]), 32'd0);
    chk("l0_csb",  32'(csb[0]),  32'd1);
    tick(3);
    @(negedge clk);
    chk("l0_busy_after", 32'(busy[0]), 32'd0);
    chk("l0_falls", 32'(fl[0].falls_csb - f0), 32'd0);

    // Start while busy is ignored
    r0 = fl[0].rises;
    f0 = fl[0].falls_csb;
    push_hex(32'h00112233);
    pulse_start(0, 24'h000010, 16'd4);
    tick(40);
    pulse_start(0, 24'h000020, 16'd8);
    wait_done(0, 2000, "sb_done");
    tick(4);
    chk("sb_cmdaddr", fl[0].ca, 32'h03000010);
    chk("sb_rises",   32'(fl[0].rises - r0), 32'd64);
    chk("sb_falls",   32'(fl[0].falls_csb - f0), 32'd1);
    chk("sb_busy",    32'(busy[0]), 32'd0);
    chk("sb_qempty",  32'(exp_q.size()), 32'd0);

    // Reset in the middle of DATA after two bytes
    push_hex(32'h00112233);
    push_hex(32'h44556677);
    pulse_start(0, 24'h000010, 16'd8);
    n = 0;
    while (exp_q.size() > 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rs_progress", 32'(exp_q.size()), 32'd6);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rs_csb",  32'(csb[0]),  32'd1);
    chk("rs_sck",  32'(sck[0]),  32'd0);
    chk("rs_dv",   32'(dv[0]),   32'd0);
    chk("rs_busy", 32'(busy[0]), 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h32);
    pulse_start(0, 24'h000020, 16'd3);
    wait_done(0, 2000, "rs_done");
    tick(4);
    chk("rs_cmdaddr", fl[0].ca, 32'h03000020);
    chk("rs_qempty",  32'(exp_q.size()), 32'd0);

    // CLK_DIV = 1: 256 bytes from 0x000000
    r0 = fl[1].rises;
    for (int i = 0; i < 256; i++) exp_q.push_back(fbyte(24'(i)));
    pulse_start(1, 24'h000000, 16'd256);
    wait_done(1, 10000, "d1_done");
    tick(4);
    chk("d1_cmdaddr", fl[1].ca, 32'h03000000);
    chk("d1_rises",   32'(fl[1].rises - r0), 32'd2080);
    chk("d1_first",   32'(fl[1].t_r1 - fl[1].t_csbf), 32'd1);
    chk("d1_period",  32'(fl[1].t_r2 - fl[1].t_r1), 32'd2);
    chk("d1_qempty",  32'(exp_q.size()), 32'd0);

    // CLK_DIV = 5: 256 bytes from 0x000000
    r0 = fl[2].rises;
    for (int i = 0; i < 256; i++) exp_q.push_back(fbyte(24'(i)));
    pulse_start(2, 24'h000000, 16'd256);
    wait_done(2, 25000, "d5_done");
    tick(4);
    chk("d5_cmdaddr", fl[2].ca, 32'h03000000);
    chk("d5_rises",   32'(fl[2].rises - r0), 32'd2080);
    chk("d5_first",   32'(fl[2].t_r1 - fl[2].t_csbf), 32'd5);
    chk("d5_period",  32'(fl[2].t_r2 - fl[2].t_r1), 32'd10);
    chk("d5_qempty",  32'(exp_q.size()), 32'd0);

    chk("mosi_stable", 32'(fl[0].mosi_bad + fl[1].mosi_bad + fl[2].mosi_bad), 32'd0);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Wishbone-clocked SPI master that fetches a contiguous byte range from the board's external SPI flash, the same serial part the management core boots from, using the standard READ command (0x03). It lets the accelerator in the user project area stream message blocks straight from flash into the SHA-256 input path without going through firmware. The reader drives the flash as initiator, shifts bytes in MSB-first and presents them on a valid/ready byte stream with backpressure.

## Interface
- CLK_DIV, 2: half-period of SCK in wb_clk_i cycles; legal ≥1.
- CSB_IDLE, 2: minimum wb_clk_i cycles CSB stays high after a transfer before done.
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- addr  in  24  flash byte address; captured on accepted start.
- len  in  16  byte count; captured on accepted start; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of transfer.
- data_o  out  8  received byte.
- data_valid  out  1  data_o holds an unconsumed byte.
- data_ready  in  1  consumer accepts; a byte transfers when data_valid && data_ready.
- spi_csb  out  1  flash chip select, active-low.
- spi_sck  out  1  SPI clock, mode 0 (idles low).
- spi_mosi  out  1  command/address out.
- spi_miso  in  1  data in.

## Operation
- Reset values: spi_csb=1, spi_sck=0, spi_mosi=0, busy=0, done=0, data_valid=0, data_o=0; FSM in IDLE.
- FSM: IDLE -> CMD (8 bits, 0x03) -> ADDR (24 bits, MSB first) -> DATA (8*len bits) -> GAP (CSB high, CSB_IDLE cycles) -> IDLE with done.
- start in IDLE with len=0: no SPI activity, CSB stays high; done pulses the cycle after start; busy stays low.
- start while busy: ignored; addr/len not recaptured.
- MOSI changes only while SCK is low (falling edge or CSB assertion); MISO sampled on each SCK rising edge. MOSI driven 0 during DATA.
- Byte assembly: shift register; after the 8th rising edge of a byte, byte moves to data_o and data_valid sets on the following cycle.
- Backpressure: one output register. At each byte boundary in DATA, if data_valid is high and data_ready is low, SCK is held low (no further edges, CSB stays low) until the byte is accepted. Accept and new-byte load in the same cycle: new byte wins, data_valid stays high.
- Last byte: SCK returns low, CSB deasserts regardless of whether the last byte has been consumed; done requires GAP expiry AND data_valid low (final byte consumed).
- Address wraps modulo 2^24 inside the flash; the reader does not track or limit it.
- wb_rst_i mid-transfer: all outputs take reset values the next edge; any pending byte discarded.

## Timing
- Accepted start at edge T: busy=1 and spi_csb=0 at T+1, MOSI=bit7 of 0x03 at T+1.
- First SCK rise at T+1+CLK_DIV; SCK period 2*CLK_DIV cycles, 50% duty.
- Total unstalled SCK cycles: 32 + 8*len.
- CSB rises CLK_DIV cycles after the final SCK rise (at the would-be falling edge).
- done pulses CSB_IDLE cycles after CSB rises (or later if last byte pending); busy falls with done.
- A new start is accepted the cycle after done.
- Unstalled byte rate: one byte per 16*CLK_DIV cycles.

## Structure
- Package spi_flash_pkg: READ opcode constant 8'h03, FSM state enum (IDLE, CMD, ADDR, DATA, GAP), command/address bit-count constants.
- Sub-module spi_sck_gen: CLK_DIV counter with enable/stall input, emits spi_sck plus one-cycle rise/fall strobes consumed by the FSM.

## Test plan
- Basic read: flash hex 00 11 22 33 at 0x000010; start addr=0x000010 len=4, data_ready=1 -> bytes 00,11,22,33 in order; MOSI sequence 0x03,0x00,0x00,0x10; 64 SCK rises; one done pulse.
- Backpressure: same read, data_ready low for 100 cycles after first byte -> SCK frozen low with CSB low, no bytes lost or duplicated; stream resumes on ready.
- len=0: start addr=0x123456 len=0 -> CSB never falls, done at T+1, busy never high.
- Start while busy: second start mid-transfer with different addr/len -> ignored; first transfer completes unaltered.
- Reset mid-DATA: assert wb_rst_i after 2 of 8 bytes -> next cycle CSB=1, SCK=0, data_valid=0; fresh start afterwards reads correct data.
- CLK_DIV=1 and CLK_DIV=5: 256-byte read from 0x000000 against loaded hex -> all bytes match; SCK period 2 and 10 cycles respectively.
